// File: rtl/tcdm_bank_model.sv
// Single TCDM memory bank: grants requests, performs byte-enabled stores and
// returns load data a fixed number of cycles after the grant.
module tcdm_bank_model #(
    parameter int NumWords   = 256,
    parameter int DataWidth  = 32,
    parameter int MemLatency = 1,
    parameter int GntPeriod  = 0,
    parameter bit InitZero   = 1'b1,
    localparam int AddrWidth = $clog2(NumWords),
    localparam int NumBytes  = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic [AddrWidth-1:0] add_i,
    input  logic                 wen_i,
    input  logic [NumBytes-1:0]  be_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 gnt_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 vld_o,
    output logic                 init_done_o
);

    if ((GntPeriod == 1) || (MemLatency == 0)) begin : g_bad_params
        $error("tcdm_bank_model: GntPeriod must be 0 or >=2 and MemLatency >=1");
    end

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e                 state;
    logic [AddrWidth-1:0]   init_ptr;
    logic                   stall;
    logic                   xfer;

    logic [DataWidth-1:0]   mem [NumWords];

    logic [MemLatency-1:0]  vld_pipe;
    logic [MemLatency-1:0]  ld_pipe;
    logic [DataWidth-1:0]   dat_pipe [MemLatency];
    logic [DataWidth-1:0]   rdata_hold;

    // Bank-conflict model: the grant drops on the last count of every period.
    if (GntPeriod >= 2) begin : g_stall
        localparam int CntWidth = $clog2(GntPeriod);
        logic [CntWidth-1:0] stall_cnt;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stall_cnt <= '0;
            end else if (state == ST_READY) begin
                if (stall_cnt == CntWidth'(GntPeriod - 1)) stall_cnt <= '0;
                else                                       stall_cnt <= stall_cnt + CntWidth'(1);
            end
        end

        assign stall = (stall_cnt == CntWidth'(GntPeriod - 1));
    end else begin : g_no_stall
        assign stall = 1'b0;
    end

    assign gnt_o = (state == ST_READY) && !stall && !rst_i;
    assign xfer  = req_i && gnt_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= InitZero ? ST_INIT : ST_READY;
            init_ptr    <= '0;
            init_done_o <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_ptr <= init_ptr + AddrWidth'(1);
                    if (init_ptr == AddrWidth'(NumWords - 1)) begin
                        state       <= ST_READY;
                        init_done_o <= 1'b1;
                    end
                end
                default: init_done_o <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == ST_INIT) begin
            mem[init_ptr] <= '0;
        end else if (xfer && wen_i) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (be_i[b]) mem[add_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Response pipeline: valid/load flags are reset so a reset drops in-flight responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe   <= '0;
            ld_pipe    <= '0;
            rdata_hold <= '0;
        end else begin
            vld_pipe[0] <= xfer;
            ld_pipe[0]  <= xfer && !wen_i;
            for (int i = 1; i < MemLatency; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                ld_pipe[i]  <= ld_pipe[i-1];
            end
            rdata_hold <= rdata_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (xfer && !wen_i) dat_pipe[0] <= mem[add_i];
        for (int i = 1; i < MemLatency; i++) begin
            dat_pipe[i] <= dat_pipe[i-1];
        end
    end

    assign vld_o   = vld_pipe[MemLatency-1];
    assign rdata_o = ld_pipe[MemLatency-1] ? dat_pipe[MemLatency-1] : rdata_hold;

endmodule

// File: tb/tb_tcdm_bank_model.sv
// Bench for tcdm_bank_model: four instances (default, latency 3, grant period 4,
// latency 2) share one request bus; a queue scoreboard checks every response.
module tb_tcdm_bank_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wen = 1'b0;
    logic [7:0]  add = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;

    logic [3:0]  gnt_w;
    logic [3:0]  vld_w;
    logic [3:0]  done_w;
    logic [31:0] rdata_w [4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sel      = 0;
    int pops     = 0;
    bit sb_en    = 1'b0;

    logic [31:0] exp_q [$];
    int          due_q [$];
    bit          ld_q  [$];
    logic [31:0] model [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tcdm_bank_model u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt_w[0]), .rdata_o(rdata_w[0]), .vld_o(vld_w[0]),
        .init_done_o(done_w[0])
    );
    tcdm_bank_model #(.MemLatency(3)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt_w[1]), .rdata_o(rdata_w[1]), .vld_o(vld_w[1]),
        .init_done_o(done_w[1])
    );
    tcdm_bank_model #(.GntPeriod(4)) u_c (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt_w[2]), .rdata_o(rdata_w[2]), .vld_o(vld_w[2]),
        .init_done_o(done_w[2])
    );
    tcdm_bank_model #(.MemLatency(2)) u_d (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt_w[3]), .rdata_o(rdata_w[3]), .vld_o(vld_w[3]),
        .init_done_o(done_w[3])
    );

    function automatic int lat(input int s);
        case (s)
            1:       return 3;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    // Scoreboard: every cycle, the selected bank's vld_o must match the queue head's due cycle.
    always @(negedge clk) begin
        bit          exp_v;
        bit          exp_ld;
        logic [31:0] exp_d;
        if (sb_en) begin
            exp_v  = 1'b0;
            exp_ld = 1'b0;
            exp_d  = '0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                exp_v = 1'b1;
                void'(due_q.pop_front());
                exp_d  = exp_q.pop_front();
                exp_ld = ld_q.pop_front();
            end
            n_checks++;
            if (vld_w[sel] !== exp_v) begin
                n_fail++;
                $display("FAIL sb_vld cyc=%0d dut=%0d got=%b exp=%b", cyc, sel, vld_w[sel], exp_v);
            end
            if (exp_v) begin
                pops++;
                if (exp_ld) begin
                    n_checks++;
                    if (rdata_w[sel] !== exp_d) begin
                        n_fail++;
                        $display("FAIL sb_rdata cyc=%0d dut=%0d got=%h exp=%h", cyc, sel, rdata_w[sel], exp_d);
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        due_q.delete();
        ld_q.delete();
        for (int i = 0; i < 256; i++) model[i] = '0;
    endtask

    // Called at posedge+1 with gnt high: the transfer lands on the next edge.
    task automatic push_exp(input bit w, input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
        due_q.push_back(cyc + lat(sel));
        ld_q.push_back(!w);
        exp_q.push_back(model[a]);
        if (w) begin
            for (int k = 0; k < 4; k++) begin
                if (b[k]) model[a][k*8 +: 8] = d[k*8 +: 8];
            end
        end
    endtask

    task automatic drive(input bit w, input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
        int n;
        req = 1'b1; wen = w; add = a; be = b; wdata = d;
        n = 0;
        while (!gnt_w[sel] && n < 50) begin
            step();
            n++;
        end
        n_checks++;
        if (!gnt_w[sel]) begin
            n_fail++;
            $display("FAIL gnt_timeout dut=%0d got=0 exp=1 within 50 cycles", sel);
        end else begin
            push_exp(w, a, b, d);
        end
        step();
    endtask

    task automatic drain();
        int n;
        req = 1'b0;
        n = 0;
        while (due_q.size() > 0 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (due_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain dut=%0d pending=%0d exp=0", sel, due_q.size());
        end
        step(4);
    endtask

    task automatic test_reset();
        int n;
        sb_en = 1'b0;
        rst = 1'b1; req = 1'b0;
        step(2);
        n_checks++;
        if (gnt_w !== 4'b0 || vld_w !== 4'b0 || done_w !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got gnt=%b vld=%b done=%b exp=0000", gnt_w, vld_w, done_w);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdata_w[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata dut=%0d got=%h exp=00000000", i, rdata_w[i]);
            end
        end
        clear_sb();
        sel = 0;
        rst = 1'b0;
        sb_en = 1'b1;
        n = 0;
        while (!gnt_w[0] && n < 400) begin
            n++;
            step();
        end
        n_checks++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL init_len got=%0d exp=256", n);
        end
        n_checks++;
        if (done_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done got=%b exp=1", done_w[0]);
        end
        drive(1'b0, 8'h3F, 4'h0, 32'h0);
        drain();
    endtask

    task automatic test_byte_enable();
        sel = 0;
        drive(1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
        drive(1'b1, 8'h10, 4'h1, 32'h000000AA);
        drive(1'b0, 8'h10, 4'h0, 32'h0);
        drain();
        n_checks++;
        if (rdata_w[0] !== 32'hDEADBEAA) begin
            n_fail++;
            $display("FAIL byte_enable got=%h exp=deadbeaa", rdata_w[0]);
        end
        drive(1'b1, 8'h11, 4'hF, 32'h12345678);
        drive(1'b1, 8'h11, 4'h0, 32'hFFFFFFFF);
        drive(1'b0, 8'h11, 4'h0, 32'h0);
        drain();
    endtask

    task automatic test_hazard();
        logic [31:0] d;
        sel = 0;
        d = $urandom();
        drive(1'b1, 8'h20, 4'hF, d);
        drive(1'b0, 8'h20, 4'h0, 32'h0);
        drain();
        n_checks++;
        if (rdata_w[0] !== d) begin
            n_fail++;
            $display("FAIL hazard got=%h exp=%h", rdata_w[0], d);
        end
        for (int i = 0; i < 24; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(128, 135)),
                  4'($urandom_range(0, 15)), $urandom());
        end
        drain();
    endtask

    task automatic test_back_to_back();
        sel = 1;
        drive(1'b1, 8'h00, 4'hF, 32'h11);
        drive(1'b1, 8'h01, 4'hF, 32'h22);
        drive(1'b1, 8'h02, 4'hF, 32'h33);
        drain();
        drive(1'b0, 8'h00, 4'h0, 32'h0);
        drive(1'b0, 8'h01, 4'h0, 32'h0);
        drive(1'b0, 8'h02, 4'h0, 32'h0);
        drain();
        drive(1'b1, 8'h05, 4'hF, 32'hCAFEF00D);
        drain();
        n_checks++;
        if (rdata_w[1] !== 32'h33) begin
            n_fail++;
            $display("FAIL rdata_hold got=%h exp=00000033", rdata_w[1]);
        end
    endtask

    task automatic test_gnt_period();
        int xfers;
        int lows;
        int last_low;
        int pops0;
        sel = 2;
        xfers = 0; lows = 0; last_low = -1; pops0 = pops;
        req = 1'b1; wen = 1'b0; be = 4'h0;
        for (int i = 0; i < 16; i++) begin
            add = 8'(8'h40 + i);
            if (gnt_w[2]) begin
                push_exp(1'b0, add, 4'h0, 32'h0);
                xfers++;
            end else begin
                if (last_low >= 0) begin
                    n_checks++;
                    if (i - last_low != 4) begin
                        n_fail++;
                        $display("FAIL gnt_spacing got=%0d exp=4", i - last_low);
                    end
                end
                last_low = i;
                lows++;
            end
            step();
        end
        drain();
        n_checks++;
        if (xfers != 12 || lows != 4) begin
            n_fail++;
            $display("FAIL gnt_count got xfers=%0d lows=%0d exp xfers=12 lows=4", xfers, lows);
        end
        n_checks++;
        if (pops - pops0 != 12) begin
            n_fail++;
            $display("FAIL vld_count got=%0d exp=12", pops - pops0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        sel = 3;
        drive(1'b1, 8'h07, 4'hF, 32'h5555AAAA);
        drive(1'b0, 8'h07, 4'h0, 32'h0);
        drain();
        n_checks++;
        if (rdata_w[3] !== 32'h5555AAAA) begin
            n_fail++;
            $display("FAIL preload_d got=%h exp=5555aaaa", rdata_w[3]);
        end
        drive(1'b0, 8'h07, 4'h0, 32'h0);
        rst = 1'b1; req = 1'b0;
        clear_sb();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (vld_w[3]) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_drop got=%0d pulses exp=0", pulses);
        end
        n_checks++;
        if (rdata_w[3] !== 32'h0 || gnt_w[3] !== 1'b0 || done_w[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outs got rdata=%h gnt=%b done=%b exp 0/0/0",
                     rdata_w[3], gnt_w[3], done_w[3]);
        end
        rst = 1'b0;
        n = 0;
        while (!gnt_w[3] && n < 400) begin
            n++;
            step();
        end
        n_checks++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL reinit_len got=%0d exp=256", n);
        end
        drive(1'b0, 8'h07, 4'h0, 32'h0);
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_byte_enable();
        test_hazard();
        test_back_to_back();
        test_gnt_period();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
